psum_accum: RTL
===============

Name: psum_accum

Overview:
- Downstream consumer of the 8-lane signed MAC array output.
- Accumulates a programmable number of signed partial sums (one per MAC evaluation) into a wider result.
- Optionally applies ReLU to the result.
- Presents the result on a valid/ready output register to the output SRAM/writeback stage.
- Sits between the MAC and the output buffer. Replaces ad-hoc accumulation in the tile controller.

Parameters:
- bw_psum, 19, width of signed input partial sum (matches MAC output: 2*8+3)
- kmax, 16, maximum partial sums per result
- lw, 5, width of len port (must hold kmax)
- bw_acc, 23, accumulator/output width = bw_psum + log2(kmax); no overflow possible by construction

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- len  input  lw  partial sums per result; sampled on first beat of a group
- relu_en  input  1  ReLU enable; sampled on first beat of a group
- in_valid  input  1  in_psum valid
- in_ready  output  1  block can accept in_psum this cycle
- in_psum  input  bw_psum  signed two's-complement partial sum
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  bw_acc  signed accumulated result (ReLU applied if enabled)
- busy  output  1  a group is partially accumulated (state ACC)

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset).
- Reset (synchronous, active-high, sampled on clk rise):
  - state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, busy=0, len_q=1, relu_q=0.
  - Reset mid-group discards the partial sum and any pending out_data.
- in_ready = !(out_valid & !out_ready). It is combinational, with no dependence on in_valid.
- Accept = in_valid & in_ready.
- Sign extension: in_psum is sign-extended to bw_acc before adding. All arithmetic is signed.
- len decode: 0 -> 1; 1..kmax as given; >kmax -> kmax.
- FSM states:
  - IDLE (cnt==0, busy=0)
  - ACC (1<=cnt<len_q, busy=1)
- IDLE on accept:
  - len_q <= decode(len), relu_q <= relu_en.
  - acc_next = sext(in_psum).
  - If decoded len==1: complete. Otherwise acc<=acc_next, cnt<=1, go to ACC.
- ACC on accept:
  - acc_next = acc + sext(in_psum).
  - If cnt+1==len_q: complete. Otherwise acc<=acc_next, cnt<=cnt+1.
  - len and relu_en changes during ACC are ignored.
- Complete:
  - out_data <= (relu_q & acc_next[bw_acc-1]) ? 0 : acc_next.
  - out_valid <= 1, acc<=0, cnt<=0, state<=IDLE.
  - relu_q for a len==1 group is the relu_en value in that same cycle.
- Latency: out_valid rises on the clk edge that accepts the last beat. It is visible the cycle after that beat is presented.
- Throughput: one psum per cycle sustained when out_ready=1. With len==1, one result per cycle.
- Output handshake:
  - out_valid & out_ready with no completion this cycle: out_valid<=0, out_data holds its value.
  - out_valid & out_ready with a simultaneous completion: out_valid stays 1 and out_data takes the new result; no bubble.
  - out_valid & !out_ready: out_data and out_valid stable; in_ready=0, so no beat is accepted or lost, including mid-group.
- No input is lost or double-counted under any in_valid/out_ready pattern.

Test Plan:
- len=8, relu_en=0, out_ready=1, in_psum=1,2,...,8 on consecutive cycles -> single out_valid pulse one cycle after beat 8, out_data=36. busy=1 during beats 2-8 and returns to 0.
- len=4, in_psum=-100,-200,50,10:
  - relu_en=0 -> out_data=-240 (0x7FFF10).
  - relu_en=1 -> out_data=0.
  - Toggling relu_en after beat 1 has no effect.
- len=16, relu_en=0:
  - Sixteen beats of -262144 (0x40000) -> out_data=-4194304 (0x400000).
  - Sixteen beats of 262143 -> 4194288 (0x3FFFF0).
- Backpressure: len=2, psums 5,6 then 7,8, out_ready=0 after first result:
  - out_data=11 holds and in_ready=0 while out_ready=0.
  - Raising out_ready resumes accepts; second result=15.
  - Exactly two results total.
- len=1 and len=0, out_ready=1, psums 3,-4,9 back-to-back -> out_data 3,-4,9 on three consecutive cycles, out_valid continuously 1.
- len=8, reset asserted one cycle after beat 3 (psums 10 each) -> out_valid=0, busy=0. Next group of eight 1s yields 8, not 38.

Source files
------------

// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums a programmable number of signed MAC outputs into a wider
// result, optionally applies ReLU, and presents it on a valid/ready output register.
module psum_accum #(
    parameter int unsigned bw_psum = 19,
    parameter int unsigned kmax    = 16,
    parameter int unsigned lw      = 5,
    parameter int unsigned bw_acc  = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [lw-1:0]     len,
    input  logic              relu_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [bw_psum-1:0] in_psum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [bw_acc-1:0] out_data,
    output logic              busy
);

    typedef enum logic {st_idle, st_acc} state_t;

    state_t              state_q, state_d;
    logic [bw_acc-1:0]   acc_q, acc_d;
    logic [lw-1:0]       cnt_q, cnt_d;
    logic [lw-1:0]       len_q, len_d;
    logic                relu_q, relu_d;
    logic                out_valid_d;
    logic [bw_acc-1:0]   out_data_d;

    logic                accept;
    logic                done;
    logic                relu_eff;
    logic [lw-1:0]       len_dec;
    logic [bw_acc-1:0]   psum_ext;
    logic [bw_acc-1:0]   acc_next;

    // A held result blocks new beats so nothing completes into an occupied register.
    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == st_acc);
    assign psum_ext = {{(bw_acc - bw_psum){in_psum[bw_psum-1]}}, in_psum};

    always_comb begin
        len_dec = len;
        if (len == '0) begin
            len_dec = lw'(1);
        end else if (len > lw'(kmax)) begin
            len_dec = lw'(kmax);
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        relu_d   = relu_q;
        relu_eff = relu_q;
        done     = 1'b0;
        acc_next = acc_q + psum_ext;
        unique case (state_q)
            st_idle: begin
                acc_next = psum_ext;
                if (accept) begin
                    len_d    = len_dec;
                    relu_d   = relu_en;
                    relu_eff = relu_en;
                    if (len_dec == lw'(1)) begin
                        done = 1'b1;
                    end else begin
                        acc_d   = acc_next;
                        cnt_d   = lw'(1);
                        state_d = st_acc;
                    end
                end
            end
            st_acc: begin
                if (accept) begin
                    if (cnt_q + lw'(1) == len_q) begin
                        done = 1'b1;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + lw'(1);
                    end
                end
            end
            default: state_d = st_idle;
        endcase
        if (done) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = st_idle;
        end
    end

    // A completion in the same cycle as a drain replaces the result without a bubble.
    always_comb begin
        out_valid_d = out_valid;
        out_data_d  = out_data;
        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (done) begin
            out_valid_d = 1'b1;
            out_data_d  = (relu_eff && acc_next[bw_acc-1]) ? '0 : acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= st_idle;
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= lw'(1);
            relu_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            relu_q    <= relu_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

endmodule
